// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg : shared types and parameter defaults for the SPI master slice
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_HOLD  = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam int SPI_DATA_W_DEF    = 12;
  localparam int SPI_CLK_DIV_DEF   = 11;
  localparam int SPI_LSB_FIRST_DEF = 1;

endpackage

`default_nettype wire

// File: rtl/spi_clk_div.sv
// ----------------------------------------------------------------------------
// spi_clk_div : free-running divider, one-cycle tick every CLK_DIV cycles,
//               synchronous clear restarts the period from zero.
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] C_TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == C_TERM)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == C_TERM);

endmodule

`default_nettype wire

// File: rtl/spi_master_cfg.sv
// ----------------------------------------------------------------------------
// spi_master_cfg : configurable-mode SPI master (IDLE/SETUP/XFER/HOLD FSM).
// Optional macro SPI_LOOPBACK_EN adds port lb routing mosi back to the sampler.
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W    = SPI_DATA_W_DEF,
  parameter int CLK_DIV   = SPI_CLK_DIV_DEF,
  parameter int LSB_FIRST = SPI_LSB_FIRST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_LOOPBACK_EN
  input  logic              lb,
`endif
  input  logic              miso,
  output logic              ready,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              done
);

  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] C_LAST_EDGE = EW'(2 * DATA_W - 1);

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                 input logic b);
    return (LSB_FIRST != 0) ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  spi_state_t        r_state;
  spi_mode_t         r_mode;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [EW-1:0]     r_edge;

  logic w_tick;
  logic w_clr;
  logic w_last;
  logic w_sample;
  logic w_sdi;

`ifdef SPI_LOOPBACK_EN
  assign w_sdi = lb ? mosi : miso;
`else
  assign w_sdi = miso;
`endif

  assign w_last   = (r_edge == C_LAST_EDGE);
  // Even edge count means the next edge leaves the idle level (leading edge).
  assign w_sample = (~r_edge[0]) ^ r_mode.cpha;
  assign w_clr    = (r_state == S_IDLE) ||
                    (w_tick && ((r_state != S_XFER) || w_last));

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_edge  <= '0;
      ready   <= 1'b1;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
      dout    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          ready <= 1'b1;
          cs    <= 1'b1;
          sclk  <= cpol;
          if (newd) begin
            r_mode  <= {cpol, cpha};
            r_edge  <= '0;
            cs      <= 1'b0;
            ready   <= 1'b0;
            r_state <= S_SETUP;
            if (!cpha) begin
              mosi <= first_bit(din);
              r_tx <= shift_out(din);
            end else begin
              r_tx <= din;
            end
          end
        end
        S_SETUP: begin
          if (w_tick) begin
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          if (w_tick) begin
            sclk   <= ~sclk;
            r_edge <= r_edge + EW'(1);
            if (w_sample) begin
              r_rx <= shift_in(r_rx, w_sdi);
            end else if (!w_last) begin
              // CPHA=0 ends on a trailing edge with no bit left to shift.
              mosi <= first_bit(r_tx);
              r_tx <= shift_out(r_tx);
            end
            if (w_last) begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            cs      <= 1'b1;
            sclk    <= r_mode.cpol;
            dout    <= r_rx;
            done    <= 1'b1;
            ready   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_cfg.sv
// ----------------------------------------------------------------------------
// tb_spi_master_cfg : scoreboard bench, two DUTs (LSB-first and MSB-first)
// sharing stimulus, with a behavioural SPI slave on the selected instance.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_master_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  newd;
  logic [11:0] din;
  logic        cpol;
  logic        cpha;
  logic        miso;
`ifdef SPI_LOOPBACK_EN
  logic        lb;
`endif
  logic [1:0]  ready, sclk, cs, mosi, done;
  logic [11:0] dout0, dout1;

  logic        sel = 1'b0;
  logic        tie = 1'b0;
  logic        force0 = 1'b0;
  logic        s_cpol = 1'b0;
  logic        s_cpha = 1'b0;
  logic [11:0] s_word = '0;
  logic        s_miso = 1'b0;
  int          s_idx = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  int          cs_cnt = 0;
  int          last_low = 0;
  int          ndone = 0;

  logic        q_mosi[$];
  logic [11:0] q_dout[$];

  int checks = 0;
  int errors = 0;

  logic        m_sclk, m_cs, m_mosi, m_done, m_ready;
  logic [11:0] m_dout;

  assign m_sclk  = sel ? sclk[1]  : sclk[0];
  assign m_cs    = sel ? cs[1]    : cs[0];
  assign m_mosi  = sel ? mosi[1]  : mosi[0];
  assign m_done  = sel ? done[1]  : done[0];
  assign m_ready = sel ? ready[1] : ready[0];
  assign m_dout  = sel ? dout1    : dout0;
  assign miso    = force0 ? 1'b0 : (tie ? m_mosi : s_miso);

  always #5 clk = ~clk;

  spi_master_cfg #(.DATA_W(12), .CLK_DIV(4), .LSB_FIRST(1)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .newd(newd[0]), .din(din), .cpol(cpol), .cpha(cpha),
`ifdef SPI_LOOPBACK_EN
    .lb(lb),
`endif
    .miso(miso), .ready(ready[0]), .sclk(sclk[0]), .cs(cs[0]), .mosi(mosi[0]),
    .dout(dout0), .done(done[0])
  );

  spi_master_cfg #(.DATA_W(12), .CLK_DIV(4), .LSB_FIRST(0)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .newd(newd[1]), .din(din), .cpol(cpol), .cpha(cpha),
`ifdef SPI_LOOPBACK_EN
    .lb(lb),
`endif
    .miso(miso), .ready(ready[1]), .sclk(sclk[1]), .cs(cs[1]), .mosi(mosi[1]),
    .dout(dout1), .done(done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic sbit(input int i);
    return sel ? s_word[11-i] : s_word[i];
  endfunction

  // Slave model, done/dout scoreboard and cs-low length monitor.
  always @(negedge clk) begin
    if (!m_cs) begin
      cs_cnt <= cs_cnt + 1;
    end else begin
      if (!prev_cs) last_low <= cs_cnt;
      cs_cnt <= 0;
    end
    if (prev_cs && !m_cs) begin
      s_idx <= 0;
      if (!s_cpha) begin
        s_miso <= sbit(0);
        s_idx  <= 1;
      end
    end else if (!m_cs && (m_sclk != prev_sclk)) begin
      if ((prev_sclk == s_cpol) ^ s_cpha) begin
        if (q_mosi.size() > 0) check("mosi_bit", 32'(m_mosi), 32'(q_mosi.pop_front()));
      end else if (s_idx < 12) begin
        s_miso <= sbit(s_idx);
        s_idx  <= s_idx + 1;
      end
    end
    if (m_done) begin
      ndone <= ndone + 1;
      if (q_dout.size() > 0) check("dout", 32'(m_dout), 32'(q_dout.pop_front()));
      else check("spurious_done", 32'(m_done), 32'd0);
    end
    prev_cs   <= m_cs;
    prev_sclk <= m_sclk;
  end

  task automatic push_bits(input logic [11:0] w, input bit lsb);
    for (int i = 0; i < 12; i++) q_mosi.push_back(lsb ? w[i] : w[11-i]);
  endtask

  task automatic start_frame(input int inst, input logic [11:0] w, input logic pol,
                             input logic pha, input logic [11:0] sw);
    @(negedge clk);
    sel = inst[0]; s_cpol = pol; s_cpha = pha; s_word = sw;
    cpol = pol; cpha = pha; din = w;
    repeat (2) @(negedge clk);
    check("idle_sclk", 32'(m_sclk), 32'(pol));
    check("idle_ready", 32'(m_ready), 32'd1);
    newd[inst] = 1'b1;
    @(negedge clk);
    newd[inst] = 1'b0;
    check("cs_fall", 32'(m_cs), 32'd0);
  endtask

  task automatic wait_done(input int limit, output time t);
    bit seen;
    seen = 1'b0;
    t = 0;
    for (int n = 0; n < limit && !seen; n++) begin
      @(negedge clk);
      if (m_done) begin
        seen = 1'b1;
        t = $time;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    time t1, t2;
    int  nd0;
    rst_n = 1'b0; newd = '0; din = '0; cpol = 1'b0; cpha = 1'b0;
`ifdef SPI_LOOPBACK_EN
    lb = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(m_cs), 32'd1);
    check("rst_sclk", 32'(m_sclk), 32'd0);
    check("rst_mosi", 32'(m_mosi), 32'd0);
    check("rst_ready", 32'(m_ready), 32'd1);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_dout", 32'(m_dout), 32'd0);
    rst_n = 1'b1;

    // Mode 0, LSB first, miso looped to mosi externally.
    tie = 1'b1;
    nd0 = ndone;
    q_dout.push_back(12'hA5C);
    push_bits(12'hA5C, 1'b1);
    start_frame(0, 12'hA5C, 1'b0, 1'b0, 12'h000);
    wait_done(200, t1);
    repeat (10) @(negedge clk);
    check("m0_cs_low", 32'(last_low), 32'd104);
    check("m0_ndone", 32'(ndone - nd0), 32'd1);
    check("m0_dout_hold", 32'(m_dout), 32'h0A5C);
    tie = 1'b0;

    // Mode 3, MSB first, slave answers 3C1.
    q_dout.push_back(12'h3C1);
    push_bits(12'h801, 1'b0);
    start_frame(1, 12'h801, 1'b1, 1'b1, 12'h3C1);
    check("m3_setup_sclk", 32'(m_sclk), 32'd1);
    wait_done(200, t1);
    @(negedge clk);
    check("m3_idle_sclk", 32'(m_sclk), 32'd1);

    // Mode 1 with a mid-frame request and mode change that must be ignored.
    nd0 = ndone;
    q_dout.push_back(12'h5A6);
    push_bits(12'h123, 1'b1);
    start_frame(0, 12'h123, 1'b0, 1'b1, 12'h5A6);
    repeat (19) @(negedge clk);
    check("m1_busy", 32'(m_ready), 32'd0);
    din = 12'hFFF; newd[0] = 1'b1; cpol = 1'b1; cpha = 1'b0;
    @(negedge clk);
    newd[0] = 1'b0; cpol = 1'b0; cpha = 1'b1;
    wait_done(200, t1);
    repeat (10) @(negedge clk);
    check("m1_ndone", 32'(ndone - nd0), 32'd1);
    check("m1_cs_low", 32'(last_low), 32'd104);

    // Reset in the middle of a mode-2 frame.
    start_frame(0, 12'h555, 1'b1, 1'b0, 12'h000);
    repeat (44) @(negedge clk);
    check("rs_sclk_pre", 32'(m_sclk), 32'd1);
    nd0 = ndone;
    #2 rst_n = 1'b0;
    #1;
    check("rs_cs", 32'(m_cs), 32'd1);
    check("rs_sclk", 32'(m_sclk), 32'd0);
    check("rs_done", 32'(m_done), 32'd0);
    repeat (3) @(negedge clk);
    check("rs_dout", 32'(m_dout), 32'd0);
    check("rs_mosi", 32'(m_mosi), 32'd0);
    rst_n = 1'b1;
    q_dout.push_back(12'h9C3);
    push_bits(12'h0F0, 1'b1);
    start_frame(0, 12'h0F0, 1'b0, 1'b0, 12'h9C3);
    wait_done(200, t1);
    repeat (5) @(negedge clk);
    check("rs_ndone", 32'(ndone - nd0), 32'd1);

    // newd held high: back-to-back frames.
    tie = 1'b1; sel = 1'b0; cpol = 1'b0; cpha = 1'b0;
    s_cpol = 1'b0; s_cpha = 1'b0;
    din = 12'h001;
    q_dout.push_back(12'h001);
    q_dout.push_back(12'h002);
    @(negedge clk);
    newd[0] = 1'b1;
    wait_done(200, t1);
    din = 12'h002;
    @(negedge clk);
    check("b2b_cs_next", 32'(m_cs), 32'd0);
    wait_done(200, t2);
    newd[0] = 1'b0;
    check("b2b_spacing", 32'((t2 - t1) / 10), 32'd105);
    repeat (10) @(negedge clk);
    check("b2b_idle", 32'(m_cs), 32'd1);
    tie = 1'b0;

`ifdef SPI_LOOPBACK_EN
    lb = 1'b1; force0 = 1'b1;
    q_dout.push_back(12'hC3A);
    start_frame(0, 12'hC3A, 1'b0, 1'b0, 12'h000);
    wait_done(200, t1);
    lb = 1'b0; force0 = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("q_dout_empty", 32'(q_dout.size()), 32'd0);
    check("q_mosi_empty", 32'(q_mosi.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
